// File: rtl/bht_update_queue_pkg.sv
// ---------------------------------------------------------------------------
// Shared type and constant definitions for the BHT update queue slice.
//
// Contents:
//   riscv      : VLEN, the virtual address width used for branch PCs.
//   ariane_pkg : TRANS_ID_BITS, bht_update_t (the {valid, pc, taken} pulse
//                to the frontend BHT), bht_uq_entry_t (one buffered branch
//                outcome) and BHT_UQ_DEPTH (default queue depth for the
//                instantiating frontend/controller).
// ---------------------------------------------------------------------------

package riscv;
    localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
    // Scoreboard with 8 entries, so transaction IDs are 3 bits wide.
    localparam int unsigned TRANS_ID_BITS = 3;

    // Default depth of the branch-outcome queue feeding the BHT.
    localparam int unsigned BHT_UQ_DEPTH = 4;

    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic                   taken;
    } bht_update_t;

    typedef struct packed {
        logic [riscv::VLEN-1:0]   pc;
        logic                     taken;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } bht_uq_entry_t;
endpackage

// File: rtl/bht_update_queue.sv
// ---------------------------------------------------------------------------
// bht_update_queue
//
// Buffers resolved conditional-branch outcomes from the branch unit, tagged
// by scoreboard transaction ID, and releases each one to the frontend BHT as
// a single-cycle bht_update_t pulse only once its instruction commits. A
// flush drops every still-speculative entry, so the predictor only ever
// learns from retired branches.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               squash all uncommitted entries
//   debug_mode_i          commits pop their entry but emit no update
//   resolve_valid_i/pc_i/taken_i/trans_id_i, resolve_ready_o
//                         enqueue side from the branch unit
//   commit_valid_i, commit_trans_id_i
//                         commit port from the scoreboard
//   bht_update_o          registered {valid, pc, taken} to the BHT
//
// Optional feature, enabled by defining BHT_UPDATE_QUEUE_STATS_EN:
//   stat_committed_o      saturating count of emitted updates
//   stat_squashed_o       saturating count of entries dropped by flush
// ---------------------------------------------------------------------------

module bht_update_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    input  logic                     resolve_valid_i,
    input  logic [riscv::VLEN-1:0]   resolve_pc_i,
    input  logic                     resolve_taken_i,
    input  logic [TRANS_ID_BITS-1:0] resolve_trans_id_i,
    output logic                     resolve_ready_o,
    input  logic                     commit_valid_i,
    input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
    output bht_update_t              bht_update_o
`ifdef BHT_UPDATE_QUEUE_STATS_EN
    ,
    output logic [31:0]              stat_committed_o,
    output logic [31:0]              stat_squashed_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry layout follows bht_uq_entry_t but tracks the TRANS_ID_BITS
    // parameter so a non-default ID width still compares correctly.
    typedef struct packed {
        logic [riscv::VLEN-1:0]   pc;
        logic                     taken;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    bht_update_t        update_q, update_d;
    logic               push;
    logic               match;
    logic [CNT_W-1:0]   dropped;

    assign resolve_ready_o = (count_q < CNT_W'(DEPTH));
    assign bht_update_o    = update_q;

    // Only the head is compared against the commit: branches resolve and
    // commit in program order. The comparison uses registered state only,
    // so a resolve arriving in the same cycle can never match its commit.
    // A flush keeps the pop/update of a matching head, then discards
    // everything left by collapsing the read pointer onto the write pointer.
    always_comb begin
        push     = resolve_valid_i && resolve_ready_o && !flush_i;
        match    = commit_valid_i && (count_q != '0)
                   && (mem_q[rdPtr_q].trans_id == commit_trans_id_i);
        rdPtr_d  = rdPtr_q;
        wrPtr_d  = wrPtr_q;
        count_d  = count_q;
        dropped  = '0;
        update_d = update_q;
        update_d.valid = 1'b0;

        if (match) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
            if (!debug_mode_i) begin
                update_d.valid = 1'b1;
                update_d.pc    = mem_q[rdPtr_q].pc;
                update_d.taken = mem_q[rdPtr_q].taken;
            end
        end
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(match);

        if (flush_i) begin
            dropped = count_q - CNT_W'(match);
            rdPtr_d = wrPtr_q;
            wrPtr_d = wrPtr_q;
            count_d = '0;
        end
    end

    // Pointer, count and output register. Reset also clears any update
    // that would otherwise have been emitted on the following cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr_q  <= '0;
            wrPtr_q  <= '0;
            count_q  <= '0;
            update_q <= '0;
        end else begin
            rdPtr_q  <= rdPtr_d;
            wrPtr_q  <= wrPtr_d;
            count_q  <= count_d;
            update_q <= update_d;
        end
    end

    // Payload storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wrPtr_q] <= '{pc:       resolve_pc_i,
                               taken:    resolve_taken_i,
                               trans_id: resolve_trans_id_i};
        end
    end

`ifdef BHT_UPDATE_QUEUE_STATS_EN
    logic [31:0] committed_q;
    logic [31:0] squashed_q;
    logic [32:0] squashSum;

    assign squashSum        = {1'b0, squashed_q} + 33'(dropped);
    assign stat_committed_o = committed_q;
    assign stat_squashed_o  = squashed_q;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            committed_q <= '0;
            squashed_q  <= '0;
        end else begin
            if (update_d.valid && (committed_q != 32'hFFFF_FFFF)) begin
                committed_q <= committed_q + 32'd1;
            end
            if (flush_i) begin
                squashed_q <= squashSum[32] ? 32'hFFFF_FFFF : squashSum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_bht_update_queue.sv
// ---------------------------------------------------------------------------
// Testbench for bht_update_queue (default build, statistics disabled).
// Directed scenarios for basic update, full queue, ID mismatch, flush,
// debug-mode commit and mid-operation reset, followed by a randomized run.
// Every cycle is compared against a queue-based reference model.
// ---------------------------------------------------------------------------

module tb_bht_update_queue;
    import ariane_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] pc;
        logic        tk;
        logic [2:0]  id;
    } modelEntry_t;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        debug_mode_i;
    logic        resolve_valid_i;
    logic [63:0] resolve_pc_i;
    logic        resolve_taken_i;
    logic [2:0]  resolve_trans_id_i;
    logic        resolve_ready_o;
    logic        commit_valid_i;
    logic [2:0]  commit_trans_id_i;
    bht_update_t bht_update_o;

    modelEntry_t modelQ[$];
    logic        expValid;
    logic [63:0] expPc;
    logic        expTk;
    int          checks;
    int          errors;

    bht_update_queue #(.DEPTH(DEPTH), .TRANS_ID_BITS(3)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .flush_i            (flush_i),
        .debug_mode_i       (debug_mode_i),
        .resolve_valid_i    (resolve_valid_i),
        .resolve_pc_i       (resolve_pc_i),
        .resolve_taken_i    (resolve_taken_i),
        .resolve_trans_id_i (resolve_trans_id_i),
        .resolve_ready_o    (resolve_ready_o),
        .commit_valid_i     (commit_valid_i),
        .commit_trans_id_i  (commit_trans_id_i),
        .bht_update_o       (bht_update_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, checks ready before the edge, advances the
    // reference model by one clock and checks the update port afterwards.
    task automatic applyStimulus(input logic rst, input logic rv, input logic [63:0] pc,
                                 input logic tk, input logic [2:0] id, input logic cv,
                                 input logic [2:0] cid, input logic fl, input logic dbg);
        logic expReady;
        logic match;
        rst_i              = rst;
        resolve_valid_i    = rv;
        resolve_pc_i       = pc;
        resolve_taken_i    = tk;
        resolve_trans_id_i = id;
        commit_valid_i     = cv;
        commit_trans_id_i  = cid;
        flush_i            = fl;
        debug_mode_i       = dbg;
        #1;
        expReady = (modelQ.size() < DEPTH);
        checkOutput("ready", resolve_ready_o, expReady);

        if (rst) begin
            modelQ.delete();
            expValid = 1'b0;
            expPc    = '0;
            expTk    = 1'b0;
        end else begin
            match    = cv && (modelQ.size() > 0) && (modelQ[0].id == cid);
            expValid = match && !dbg;
            if (expValid) begin
                expPc = modelQ[0].pc;
                expTk = modelQ[0].tk;
            end
            if (match) void'(modelQ.pop_front());
            if (fl) modelQ.delete();
            else if (rv && expReady) modelQ.push_back('{pc: pc, tk: tk, id: id});
        end

        @(posedge clk_i);
        #1;
        checkOutput("valid", bht_update_o.valid, expValid);
        checkOutput("pc",    bht_update_o.pc,    expPc);
        checkOutput("taken", bht_update_o.taken, expTk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [63:0] pc, input logic tk, input logic [2:0] id);
        applyStimulus(0, 1, pc, tk, id, 0, 0, 0, 0);
    endtask

    task automatic commit(input logic [2:0] cid);
        applyStimulus(0, 0, '0, 0, 0, 1, cid, 0, 0);
    endtask

    initial begin
        logic [63:0] rpc;
        logic [2:0]  rid;
        logic [2:0]  cid;
        checks   = 0;
        errors   = 0;
        expValid = 0;
        expPc    = '0;
        expTk    = 0;

        rst_i = 1; flush_i = 0; debug_mode_i = 0; resolve_valid_i = 0;
        resolve_pc_i = '0; resolve_taken_i = 0; resolve_trans_id_i = '0;
        commit_valid_i = 0; commit_trans_id_i = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        checkOutput("rstValid", bht_update_o.valid, 0);
        checkOutput("rstPc",    bht_update_o.pc,    0);
        checkOutput("rstReady", resolve_ready_o,    1);

        // Basic: resolve, wait, commit, one-cycle pulse
        resolve(64'h8000_0010, 1, 3);
        idle();
        commit(3);
        checkOutput("basicValid", bht_update_o.valid, 1);
        checkOutput("basicPc",    bht_update_o.pc,    64'h8000_0010);
        checkOutput("basicTaken", bht_update_o.taken, 1);
        idle();
        checkOutput("basicPulse", bht_update_o.valid, 0);

        // Full: fifth resolve held across a pop, accepted the next cycle
        for (int i = 0; i < 4; i++) resolve(64'h1000 + 64'(i * 4), i[0], 3'(i));
        checkOutput("fullReady", resolve_ready_o, 0);
        applyStimulus(0, 1, 64'h2000, 1, 4, 1, 0, 0, 0);
        checkOutput("fullReadyBack", resolve_ready_o, 1);
        resolve(64'h2000, 1, 4);
        for (int i = 1; i < 5; i++) commit(3'(i));
        checkOutput("fullDrainPc", bht_update_o.pc, 64'h2000);

        // Mismatch: non-head ID ignored, then matching ID emits
        resolve(64'h3000, 0, 5);
        commit(4);
        checkOutput("mismatchValid", bht_update_o.valid, 0);
        commit(5);
        checkOutput("matchValid", bht_update_o.valid, 1);

        // Flush: head commit honoured, the rest dropped
        resolve(64'h4000, 1, 1);
        resolve(64'h4004, 0, 2);
        resolve(64'h4008, 1, 3);
        applyStimulus(0, 0, '0, 0, 0, 1, 1, 1, 0);
        checkOutput("flushValid", bht_update_o.valid, 1);
        checkOutput("flushPc",    bht_update_o.pc,    64'h4000);
        commit(2);
        checkOutput("flushEmpty", bht_update_o.valid, 0);

        // Debug: entry popped silently
        resolve(64'h5000, 1, 7);
        applyStimulus(0, 0, '0, 0, 0, 1, 7, 0, 1);
        checkOutput("debugValid", bht_update_o.valid, 0);
        commit(7);
        checkOutput("debugPopped", bht_update_o.valid, 0);

        // Reset mid-operation discards entries and clears outputs
        resolve(64'h6000, 1, 1);
        resolve(64'h6004, 1, 2);
        resolve(64'h6008, 0, 3);
        applyStimulus(1, 0, '0, 0, 0, 0, 0, 0, 0);
        commit(1);
        checkOutput("resetValid", bht_update_o.valid, 0);
        checkOutput("resetPc",    bht_update_o.pc,    0);
        checkOutput("resetReady", resolve_ready_o,    1);

        // Randomized run against the reference model
        for (int n = 0; n < 400; n++) begin
            rpc = {$urandom, $urandom};
            rid = 3'($urandom_range(0, 7));
            if (modelQ.size() > 0 && ($urandom_range(0, 2) != 0)) cid = modelQ[0].id;
            else cid = 3'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 63) == 0),
                          1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 1)), rid,
                          ($urandom_range(0, 3) != 0), cid,
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bht_update_queue.md
# bht_update_queue

Producer side of the branch-history-table update interface. It buffers resolved conditional-branch outcomes from the branch unit, tagged by scoreboard transaction ID, and holds each one until its instruction commits. Only then does it drive a single-cycle `bht_update_t` pulse to the frontend BHT. Speculative outcomes are discarded on flush, so the predictor is trained only on architecturally retired branches.

## Interface
Parameters:
- `DEPTH`, 4: number of buffered branch outcomes; must be a power of two and at least 2.
- `TRANS_ID_BITS`, `ariane_pkg::TRANS_ID_BITS`: width of the scoreboard transaction ID.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset. Synchronous, active-high, one clock domain.
- `flush_i` input 1: squash all uncommitted entries.
- `debug_mode_i` input 1: commits in debug mode retire silently.
- `resolve_valid_i` input 1: branch unit has a resolved conditional branch.
- `resolve_pc_i` input `riscv::VLEN`: PC of the branch.
- `resolve_taken_i` input 1: actual direction of the branch.
- `resolve_trans_id_i` input `TRANS_ID_BITS`: scoreboard ID of the branch.
- `resolve_ready_o` output 1: queue can accept a resolve.
- `commit_valid_i` input 1: an instruction commits this cycle.
- `commit_trans_id_i` input `TRANS_ID_BITS`: ID of the committing instruction.
- `bht_update_o` output `ariane_pkg::bht_update_t`: `{valid, pc, taken}` to the BHT.

## Operation
- The queue is a circular FIFO with a read pointer, a write pointer and a count of `$clog2(DEPTH)+1` bits. Pointers wrap modulo `DEPTH`.
- **Enqueue:** an entry is written when `resolve_valid_i && resolve_ready_o && !flush_i`. The entry stores `{pc, taken, trans_id}`.
- `resolve_ready_o` equals `count < DEPTH` and is derived from registered state only.
- A resolve presented while the queue is full is not accepted. The branch unit must hold it.
- **Commit match:** a commit matches when `commit_valid_i`, the queue is non-empty, and `head.trans_id == commit_trans_id_i`. Branches resolve and commit in program order, so only the head is compared.
- On a match, the head is popped. In the next cycle `bht_update_o` = `{valid=1, pc=head.pc, taken=head.taken}`, unless `debug_mode_i` is high. In that case the pop occurs but `valid` stays 0.
- A commit that does not match (non-branch instruction, or empty queue) is ignored.
- **Same-cycle resolve and commit with the same ID:** no match. The commit sees only pre-existing entries, and the resolved entry is enqueued normally. The upstream pipeline guarantees a resolve precedes its commit by at least one cycle.
- **Simultaneous push and pop:** both take effect and the count is unchanged. Push on full is blocked even if a pop occurs the same cycle.
- **Flush:** a commit match in the flush cycle is honoured first (it pops and emits an update). All remaining entries are then dropped: count is 0 and read pointer equals write pointer. A resolve in the flush cycle is dropped.
- `bht_update_o.valid` is high for exactly one cycle per matched commit. `pc` and `taken` hold their last values when `valid` is 0.

## Timing
- Commit match to `bht_update_o.valid`: 1 cycle. The output is registered.
- Resolve to entry visible for matching: 1 cycle.
- Throughput: one enqueue and one update per cycle.
- **Reset:** `rst_i` sampled high clears the pointers and count and drives `bht_update_o` to all zeros. The next cycle `resolve_ready_o` = 1.
- A reset asserted mid-operation discards all entries, and any update pending for the following cycle is suppressed.
- Entry payload storage needs no reset.

## Configuration
- Macro `BHT_UPDATE_QUEUE_STATS_EN`.
- **Defined:** adds two outputs.
  - `stat_committed_o` output 32: count of emitted updates (`valid=1`).
  - `stat_squashed_o` output 32: count of entries dropped by flush. It increments by the number of entries dropped, computed after the flush-cycle pop.
  - Both counters saturate at `32'hFFFF_FFFF` and reset to 0.
- **Undefined:** the outputs and counters do not exist, and behaviour is otherwise identical.

## Structure
- `ariane_pkg` gains `bht_uq_entry_t` (packed `{pc[VLEN], taken, trans_id}`).
- `ariane_pkg` gains constant `BHT_UQ_DEPTH = 4`. The instantiating frontend or controller uses it to set `DEPTH`.
- `bht_update_t` is reused from `ariane_pkg` unchanged.
- Single module with no sub-module. The FIFO is inline because the head-compare and flush-after-pop ordering do not fit a generic FIFO.

## Test plan
- **Basic:** resolve `{pc=0x8000_0010, taken=1, id=3}`, then commit `id=3` two cycles later -> one cycle later, `bht_update_o = {1, 0x8000_0010, 1}` for exactly one cycle.
- **Full:** four resolves with IDs 0..3 and no commits -> `resolve_ready_o` = 0. A fifth resolve is held. Commit `id=0` -> ready returns to 1 on the next cycle, and the held resolve is accepted.
- **Mismatch:** queue holds `id=5`; commit `id=4` -> no update and count stays 1. Commit `id=5` -> update emitted.
- **Flush:** queue holds IDs 1, 2, 3; commit `id=1` together with `flush_i` -> the `id=1` update is emitted, the queue is empty, and `stat_squashed_o` += 2 when stats are enabled.
- **Debug:** queue holds `id=7`; commit `id=7` with `debug_mode_i` = 1 -> the entry is popped and `bht_update_o.valid` stays 0.
- **Reset:** three entries queued; assert `rst_i` for one cycle, then commit the old head ID -> no update, `resolve_ready_o` = 1, and all outputs are zero.
